sinc3_bitstream_decimator: RTL

Receive-side counterpart to the team's second-order sigma-delta modulator. Takes the 1-bit modulator output stream and reconstructs multibit signed samples. It does this with a 3rd-order CIC (sinc3) decimation filter, decimation ratio R = 2**decim_log2. It sits after the modulator, or after the loopback/capture of its `state` bit, and feeds sample-rate logic with a one-cycle valid strobe.

---
 rtl/sinc3_bitstream_decimator_if.sv | 11 +
 rtl/sinc3_bitstream_decimator.sv | 61 ++++++
 2 files changed

// File: rtl/sinc3_bitstream_decimator_if.sv
// sinc3_bitstream_decimator_if: bitstream input and decimated sample output bundle
interface sinc3_bitstream_decimator_if #(
  parameter int out_bw = 16
);
  logic                     bit_in;
  logic                     bit_en;
  logic signed [out_bw-1:0] sample;
  logic                     sample_valid;
  modport master (output bit_in, bit_en, input sample, sample_valid);
  modport slave  (input bit_in, bit_en, output sample, sample_valid);
endinterface

// File: rtl/sinc3_bitstream_decimator.sv
// sinc3_bitstream_decimator: 3rd-order CIC decimator turning a 1-bit sigma-delta stream into signed samples
module sinc3_bitstream_decimator #(
  parameter int decim_log2 = 5,
  parameter int out_bw     = 16
) (
  input logic clk,
  input logic rst,
  sinc3_bitstream_decimator_if.slave s
);
  localparam int W = 3 * decim_log2 + 2;
  logic signed [W-1:0]      r_i1, r_i2, r_i3, r_d1, r_d2, r_d3;
  logic signed [W-1:0]      w_x, w_c1, w_c2, w_c3;
  logic [decim_log2-1:0]    r_cnt;
  logic                     r_dump;
  logic [1:0]               r_warm;
  logic signed [out_bw-1:0] r_sample;
  logic                     r_valid;
  // bit 1 -> +1, bit 0 -> -1 (all ones)
  assign w_x  = {{(W-1){~s.bit_in}}, 1'b1};
  assign w_c1 = r_i3 - r_d1;
  assign w_c2 = w_c1 - r_d2;
  assign w_c3 = w_c2 - r_d3;
  assign s.sample       = r_sample;
  assign s.sample_valid = r_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i1     <= '0;
      r_i2     <= '0;
      r_i3     <= '0;
      r_d1     <= '0;
      r_d2     <= '0;
      r_d3     <= '0;
      r_cnt    <= '0;
      r_dump   <= 1'b0;
      r_warm   <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_dump  <= s.bit_en && (r_cnt == '1);
      if (s.bit_en) begin
        r_i1  <= r_i1 + w_x;
        r_i2  <= r_i2 + r_i1;
        r_i3  <= r_i3 + r_i2;
        r_cnt <= r_cnt + 1'b1;
      end
      // first three dumps only prime the comb delays
      if (r_dump) begin
        r_d1 <= r_i3;
        r_d2 <= w_c1;
        r_d3 <= w_c2;
        if (r_warm == 2'd3) begin
          r_sample <= out_bw'(w_c3 >>> (W - out_bw));
          r_valid  <= 1'b1;
        end else begin
          r_warm <= r_warm + 1'b1;
        end
      end
    end
  end
endmodule
